// File: rtl/ula_pkg.sv
// Shared constants for the 8-bit 74181-style ALU: function select codes and mode values.
package ula_pkg;

    localparam logic MODE_LOGIC = 1'b1;
    localparam logic MODE_ARITH = 1'b0;

    // Arithmetic-mode names (result before c_in is added)
    localparam logic [3:0] FN_PASS_A  = 4'b0000;
    localparam logic [3:0] FN_OR      = 4'b0001;
    localparam logic [3:0] FN_ORN     = 4'b0010;
    localparam logic [3:0] FN_ONES    = 4'b0011;
    localparam logic [3:0] FN_SUB     = 4'b0110;
    localparam logic [3:0] FN_ADD     = 4'b1001;
    localparam logic [3:0] FN_DOUBLE  = 4'b1100;
    localparam logic [3:0] FN_DEC     = 4'b1111;

    // Logic-mode names
    localparam logic [3:0] FN_NOT_A   = 4'b0000;
    localparam logic [3:0] FN_ZERO    = 4'b0011;
    localparam logic [3:0] FN_XOR     = 4'b0110;
    localparam logic [3:0] FN_AND     = 4'b1011;
    localparam logic [3:0] FN_ALL_ONE = 4'b1100;
    localparam logic [3:0] FN_COPY_A  = 4'b1111;

endpackage

// File: rtl/ula_4_bits.sv
// Combinational 4-bit ALU slice using 74181 X/Y intermediate terms, with carry out and
// slice-local operand equality.
module ula_4_bits
    import ula_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] s,
    input  logic       m,
    input  logic       c_in,
    output logic [3:0] f,
    output logic       c_out,
    output logic       a_eq_b
);

    logic [3:0] x_term;
    logic [3:0] y_term;
    logic [4:0] sum;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_bit
            assign x_term[gi] = a[gi] | (b[gi] & s[0]) | (~b[gi] & s[1]);
            assign y_term[gi] = (a[gi] & ~b[gi] & s[2]) | (a[gi] & b[gi] & s[3]);
        end
    endgenerate

    assign sum = {1'b0, x_term} + {1'b0, y_term} + {4'b0000, c_in};

    always_comb begin
        f     = sum[3:0];
        c_out = sum[4];
        if (m == MODE_LOGIC) begin
            f     = ~(x_term ^ y_term);
            c_out = 1'b0;
        end
    end

    assign a_eq_b = (a == b);

endmodule

// File: rtl/ula_8_bits.sv
// Registered 8-bit ALU built from two ripple-carried 4-bit slices.
// Optional `zero` output is enabled by defining ULA_ZERO_FLAG_EN.
module ula_8_bits
    import ula_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [3:0] s,
    input  logic       m,
    input  logic       c_in,
    output logic [7:0] f,
    output logic       a_eq_b,
`ifdef ULA_ZERO_FLAG_EN
    output logic       zero,
`endif
    output logic       c_out
);

    logic [7:0] f_next;
    logic [1:0] carry;
    logic [1:0] slice_eq;
    logic [2:0] carry_chain;
    logic       c_out_next;
    logic       a_eq_b_next;

    logic [7:0] f_reg;
    logic       c_out_reg;
    logic       a_eq_b_reg;

    // Slice 0 takes the external carry; each slice feeds the next.
    assign carry_chain[0] = c_in;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slice
            ula_4_bits u_slice (
                .a      (a[gi*4 +: 4]),
                .b      (b[gi*4 +: 4]),
                .s      (s),
                .m      (m),
                .c_in   (carry_chain[gi]),
                .f      (f_next[gi*4 +: 4]),
                .c_out  (carry[gi]),
                .a_eq_b (slice_eq[gi])
            );
            assign carry_chain[gi+1] = carry[gi];
        end
    endgenerate

    assign c_out_next  = carry_chain[2];
    assign a_eq_b_next = &slice_eq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_reg      <= 8'h00;
            c_out_reg  <= 1'b0;
            a_eq_b_reg <= 1'b0;
        end else begin
            f_reg      <= f_next;
            c_out_reg  <= c_out_next;
            a_eq_b_reg <= a_eq_b_next;
        end
    end

    assign f      = f_reg;
    assign c_out  = c_out_reg;
    assign a_eq_b = a_eq_b_reg;

`ifdef ULA_ZERO_FLAG_EN
    logic zero_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_reg <= 1'b1;
        end else begin
            zero_reg <= (f_next == 8'h00);
        end
    end

    assign zero = zero_reg;
`endif

endmodule

// File: tb/tb_ula_8_bits.sv
// Scoreboard bench for ula_8_bits: expected results are queued when an operation is
// driven and compared one cycle later at the falling edge.
module tb_ula_8_bits;
    import ula_pkg::*;

    typedef struct packed {
        logic [7:0] f;
        logic       c_out;
        logic       a_eq_b;
        logic       zero;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] s;
    logic       m;
    logic       c_in;
    logic [7:0] f;
    logic       a_eq_b;
    logic       c_out;
`ifdef ULA_ZERO_FLAG_EN
    logic       zero;
`endif

    int checks = 0;
    int errors = 0;
    exp_t sb_q[$];

    ula_8_bits dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .b      (b),
        .s      (s),
        .m      (m),
        .c_in   (c_in),
        .f      (f),
        .a_eq_b (a_eq_b),
`ifdef ULA_ZERO_FLAG_EN
        .zero   (zero),
`endif
        .c_out  (c_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit expired, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [7:0] aa, input logic [7:0] bb,
                                   input logic [3:0] ss, input logic mm, input logic cc);
        exp_t e;
        logic [7:0] x;
        logic [7:0] y;
        logic [8:0] sum;
        x = aa | (bb & {8{ss[0]}}) | (~bb & {8{ss[1]}});
        y = (aa & ~bb & {8{ss[2]}}) | (aa & bb & {8{ss[3]}});
        if (mm) begin
            e.f     = ~(x ^ y);
            e.c_out = 1'b0;
        end else begin
            sum     = {1'b0, x} + {1'b0, y} + {8'h00, cc};
            e.f     = sum[7:0];
            e.c_out = sum[8];
        end
        e.a_eq_b = (aa == bb);
        e.zero   = (e.f == 8'h00);
        return e;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".f"}, {24'h0, f}, 32'h00);
        chk({tag, ".c_out"}, {31'h0, c_out}, 32'h0);
        chk({tag, ".a_eq_b"}, {31'h0, a_eq_b}, 32'h0);
`ifdef ULA_ZERO_FLAG_EN
        chk({tag, ".zero"}, {31'h0, zero}, 32'h1);
`endif
    endtask

    // Drive at the falling edge, queue the expectation, compare one cycle later.
    task automatic do_op(input string tag, input logic [7:0] aa, input logic [7:0] bb,
                         input logic [3:0] ss, input logic mm, input logic cc, input exp_t e);
        exp_t got_e;
        a = aa; b = bb; s = ss; m = mm; c_in = cc;
        sb_q.push_back(e);
        @(negedge clk);
        if (sb_q.size() == 0) begin
            chk({tag, ".queue"}, 32'h0, 32'h1);
        end else begin
            got_e = sb_q.pop_front();
            chk({tag, ".f"}, {24'h0, f}, {24'h0, got_e.f});
            chk({tag, ".c_out"}, {31'h0, c_out}, {31'h0, got_e.c_out});
            chk({tag, ".a_eq_b"}, {31'h0, a_eq_b}, {31'h0, got_e.a_eq_b});
`ifdef ULA_ZERO_FLAG_EN
            chk({tag, ".zero"}, {31'h0, zero}, {31'h0, got_e.zero});
`endif
        end
        $display("op %s a=%02h b=%02h s=%04b m=%0d c_in=%0d -> f=%02h c_out=%0d a_eq_b=%0d",
                 tag, aa, bb, ss, mm, cc, f, c_out, a_eq_b);
    endtask

    function automatic exp_t cexp(input logic [7:0] ff, input logic co, input logic eq);
        exp_t e;
        e.f = ff; e.c_out = co; e.a_eq_b = eq; e.zero = (ff == 8'h00);
        return e;
    endfunction

    logic [7:0] pa [4] = '{8'h00, 8'h55, 8'hFF, 8'hAA};
    logic [7:0] pb [4] = '{8'h00, 8'h33, 8'h01, 8'hAA};

    initial begin
        rst_n = 1'b0; a = 8'h3C; b = 8'h3C; s = 4'b1001; m = 1'b0; c_in = 1'b1;
        #1;
        check_reset_outputs("reset_initial");
        @(negedge clk); @(negedge clk);
        check_reset_outputs("reset_held");
        rst_n = 1'b1;

        // Directed arithmetic with constant expectations
        do_op("add_0f_01", 8'h0F, 8'h01, FN_ADD, MODE_ARITH, 1'b0, cexp(8'h10, 1'b0, 1'b0));
        do_op("add_ff_01", 8'hFF, 8'h01, FN_ADD, MODE_ARITH, 1'b0, cexp(8'h00, 1'b1, 1'b0));
        do_op("sub_55_33", 8'h55, 8'h33, FN_SUB, MODE_ARITH, 1'b1, cexp(8'h22, 1'b1, 1'b0));
        do_op("sub_33_55", 8'h33, 8'h55, FN_SUB, MODE_ARITH, 1'b1, cexp(8'hDE, 1'b0, 1'b0));
        do_op("dec_00",    8'h00, 8'h00, FN_DEC, MODE_ARITH, 1'b0, cexp(8'hFF, 1'b0, 1'b1));

        // Directed logic and equality
        do_op("xor_aa_55", 8'hAA, 8'h55, FN_XOR,   MODE_LOGIC, 1'b1, cexp(8'hFF, 1'b0, 1'b0));
        do_op("and_aa_55", 8'hAA, 8'h55, FN_AND,   MODE_LOGIC, 1'b1, cexp(8'h00, 1'b0, 1'b0));
        do_op("nota_aa",   8'hAA, 8'h55, FN_NOT_A, MODE_LOGIC, 1'b0, cexp(8'h55, 1'b0, 1'b0));
        do_op("eq_aa_aa",  8'hAA, 8'hAA, FN_NOT_A, MODE_LOGIC, 1'b0, cexp(8'h55, 1'b0, 1'b1));
        do_op("eq_aa_ab",  8'hAA, 8'hAB, FN_NOT_A, MODE_LOGIC, 1'b0, cexp(8'h55, 1'b0, 1'b0));

        // Logic sweep over all selects
        for (int i = 0; i < 16; i++) begin
            do_op("logic_aa55", 8'hAA, 8'h55, i[3:0], MODE_LOGIC, 1'b1,
                  model(8'hAA, 8'h55, i[3:0], 1'b1, 1'b1));
            do_op("logic_f00f", 8'hF0, 8'h0F, i[3:0], MODE_LOGIC, 1'b0,
                  model(8'hF0, 8'h0F, i[3:0], 1'b1, 1'b0));
        end

        // Arithmetic sweep: all selects, both carries, four operand pairs
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 16; i++) begin
                for (int c = 0; c < 2; c++) begin
                    do_op("arith_sweep", pa[p], pb[p], i[3:0], MODE_ARITH, c[0],
                          model(pa[p], pb[p], i[3:0], 1'b0, c[0]));
                end
            end
        end

        // Asynchronous clear with nonzero outputs, no clock edge needed
        do_op("pre_reset", 8'h77, 8'h77, FN_ADD, MODE_ARITH, 1'b1, cexp(8'hEF, 1'b0, 1'b1));
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("reset_async");

        // Reset mid-stream: operation presented across an edge under reset is discarded
        a = 8'h12; b = 8'h12; s = FN_ADD; m = MODE_ARITH; c_in = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset_midstream");
        rst_n = 1'b1;
        do_op("post_reset", 8'h12, 8'h34, FN_ADD, MODE_ARITH, 1'b0, cexp(8'h46, 1'b0, 1'b0));
        do_op("post_rst_or", 8'hF0, 8'h0F, FN_OR, MODE_ARITH, 1'b1, cexp(8'h00, 1'b1, 1'b0));

        chk("queue_empty", sb_q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
